ahbarb: RTL and testbench
=========================

Name: ahbarb

Overview:
- AHB-Lite-to-multi-master bus arbiter that shares one AHB slave port between up to four bus masters.
- Masters are the rotate core's read and write ahbif instances plus spare slots.
- Accepts per-master HBUSREQ/HLOCK and issues one-hot HGRANT, HMASTER and HMASTLOCK.
- Uses round-robin priority, never breaks a fixed-length burst, and caps tenure of undefined-length bursts.

Parameters:
NUM_MASTERS, 4, number of requesters; only 4 supported (HMASTER width fixed at 2).
DEFAULT_MASTER, 0, master granted when nobody requests.
MAX_TENURE, 16, max accepted beats per tenure for SINGLE/INCR traffic before forced re-arbitration (range 1..255).

Ports:
I_AHBARB_HCLK  in  1  bus clock; all state updates on rising edge.
I_AHBARB_HRESET  in  1  asynchronous, active-high reset.
I_AHBARB_HBUSREQ  in  4  per-master bus request.
I_AHBARB_HLOCK  in  4  per-master locked-transfer request.
I_AHBARB_HTRANS  in  2  HTRANS of the currently owning master (muxed bus).
I_AHBARB_HBURST  in  3  HBURST of the owning master.
I_AHBARB_HREADY  in  1  slave ready; transfer accepted when high.
O_AHBARB_HGRANT  out  4  one-hot grant; registered.
O_AHBARB_HMASTER  out  2  index of the address-phase owner; registered.
O_AHBARB_HMASTLOCK  out  1  owner's lock, aligned with HMASTER.

Behaviour:
- Reset (async, I_AHBARB_HRESET=1):
  - HGRANT=4'b0001 (one-hot DEFAULT_MASTER), HMASTER=0, HMASTLOCK=0.
  - last_grant=DEFAULT_MASTER, remaining=0, tenure=0, state=ARB.
- Accepted transfer: a rising edge with HREADY=1 and HTRANS=NSEQ(10) or SEQ(11). BUSY(01) and IDLE(00) are never counted.
- States:
  - ARB: free to re-arbitrate.
  - BURST: fixed-length burst in progress.
  - LOCK: owner holds HLOCK.
- Burst tracking:
  - Accepted NSEQ with HBURST in {WRAP4 010, INCR4 011, WRAP8 100, INCR8 101, WRAP16 110, INCR16 111} loads remaining=beats-1 (3/7/15) and enters BURST.
  - Each accepted SEQ decrements remaining; BUSY holds it.
  - HTRANS=IDLE or a new NSEQ with HREADY=1 while in BURST is an early termination: remaining cleared, return to ARB.
- Re-arbitration point: an edge with HREADY=1 and any of:
  - state=ARB;
  - state=BURST with an accepted SEQ taking remaining from 1 to 0.
- Arbitration at a re-arbitration point:
  - Current grantee has HLOCK=1 and HBUSREQ=1: grant kept, state=LOCK. LOCK exits to ARB on the first HREADY edge with HLOCK of the owner low.
  - Otherwise, round-robin search starting at last_grant+1 mod 4. The first master with HBUSREQ=1 wins.
  - If the current grantee is the only requester, it keeps the grant.
  - If none request, grant DEFAULT_MASTER.
  - last_grant updates only when the winner differs from the current grantee.
- Tenure limit:
  - The tenure counter increments per accepted transfer while state=ARB.
  - It clears whenever HGRANT changes.
  - When tenure>=MAX_TENURE and another master requests, the current grantee is excluded from the search at the next re-arbitration point.
  - Never applies in BURST or LOCK.
- Timing:
  - HGRANT changes only on HREADY=1 edges.
  - HMASTER/HMASTLOCK load the index and HLOCK of the granted master on the next HREADY=1 edge after HGRANT changes (one-beat handover). They hold while HREADY=0.
- Simultaneous events: a new request arriving on the re-arbitration edge is considered; a request dropping on that edge is not granted.
- HGRANT is always exactly one-hot; no cycle has zero or multiple grants.
- Reset asserted mid-burst: immediate return to reset values, burst abandoned.

Test Plan:
- Reset, no requests → HGRANT=0001, HMASTER=0, HMASTLOCK=0 held indefinitely.
- Masters 1 and 2 request continuously with SINGLE transfers, HREADY=1 → grant alternates 0010/0100 each re-arbitration. HMASTER follows one HREADY edge behind HGRANT.
- Master 1 issues INCR8 with master 3 requesting and HREADY low 2 cycles mid-burst, plus one BUSY → HGRANT stays 0010 through all 8 beats. It switches to 1000 only on the edge accepting beat 8.
- Master 2 issues undefined INCR while master 0 requests, MAX_TENURE=16 → grant moves to master 0 after the 16th accepted beat, not before.
- Master 3 asserts HLOCK with INCR4 followed by SINGLEs, others requesting → grant held until HLOCK drops. HMASTLOCK=1 while HMASTER=3.
- Reset asserted during beat 3 of an INCR16 → HGRANT=0001 and HMASTER=0 immediately. After release, the burst counter is clear and re-arbitration occurs on the first HREADY edge.

Source files
------------

// File: rtl/ahbarb.sv
// Four-master AHB arbiter: round-robin grant, fixed bursts never broken,
// locked sequences held, undefined-length traffic capped at MAX_TENURE beats.
module ahbarb #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_TENURE     = 16
) (
    input  logic                   I_AHBARB_HCLK,
    input  logic                   I_AHBARB_HRESET,
    input  logic [NUM_MASTERS-1:0] I_AHBARB_HBUSREQ,
    input  logic [NUM_MASTERS-1:0] I_AHBARB_HLOCK,
    input  logic [1:0]             I_AHBARB_HTRANS,
    input  logic [2:0]             I_AHBARB_HBURST,
    input  logic                   I_AHBARB_HREADY,
    output logic [NUM_MASTERS-1:0] O_AHBARB_HGRANT,
    output logic [1:0]             O_AHBARB_HMASTER,
    output logic                   O_AHBARB_HMASTLOCK
);

    typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCK} state_t;

    localparam logic [1:0] DEF_IDX    = 2'(DEFAULT_MASTER);
    localparam logic [7:0] TENURE_MAX = 8'(MAX_TENURE);

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [1:0]             master_q, master_d;
    logic                   mastlock_q, mastlock_d;
    logic [1:0]             last_q, last_d;
    logic [3:0]             remaining_q, remaining_d;
    logic [7:0]             tenure_q, tenure_d;

    logic                   is_idle, is_nseq, is_seq, accepted;
    logic                   fixed_burst, incr_hold;
    logic [3:0]             burst_len_m1;
    logic [1:0]             cur_idx, winner, search_idx;
    logic                   found, others_req, tenure_cap, rearb;
    logic [7:0]             tenure_sum;
    logic [NUM_MASTERS-1:0] cand;

    always_comb begin
        is_idle     = (I_AHBARB_HTRANS == 2'b00);
        is_nseq     = (I_AHBARB_HTRANS == 2'b10);
        is_seq      = (I_AHBARB_HTRANS == 2'b11);
        accepted    = I_AHBARB_HREADY && I_AHBARB_HTRANS[1];
        fixed_burst = (I_AHBARB_HBURST[2:1] != 2'b00);
        // Undefined INCR keeps the grant until it ends or exhausts its tenure.
        incr_hold   = (I_AHBARB_HBURST == 3'b001) && !is_idle;
        unique case (I_AHBARB_HBURST[2:1])
            2'b01:   burst_len_m1 = 4'd3;
            2'b10:   burst_len_m1 = 4'd7;
            default: burst_len_m1 = 4'd15;
        endcase
    end

    always_comb begin
        cur_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) cur_idx = 2'(i);
        end
        others_req = |(I_AHBARB_HBUSREQ & ~grant_q);
        tenure_sum = (tenure_q == 8'hFF) ? tenure_q : tenure_q + {7'd0, accepted};
        tenure_cap = (tenure_sum >= TENURE_MAX) && others_req;
        cand       = I_AHBARB_HBUSREQ & ~(((state_q == ST_ARB) && tenure_cap) ? grant_q : '0);
        // Search from last_grant+1; the current grantee is visited last.
        winner     = DEF_IDX;
        found      = 1'b0;
        search_idx = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            search_idx = last_q + 2'(i);
            if (!found && cand[search_idx]) begin
                winner = search_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        master_d    = master_q;
        mastlock_d  = mastlock_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        tenure_d    = tenure_q;
        rearb       = 1'b0;
        if (I_AHBARB_HREADY) begin
            master_d   = cur_idx;
            mastlock_d = I_AHBARB_HLOCK[cur_idx];
            unique case (state_q)
                ST_ARB: begin
                    tenure_d = tenure_sum;
                    if (is_nseq && fixed_burst) begin
                        state_d     = ST_BURST;
                        remaining_d = burst_len_m1;
                    end else if (!incr_hold || tenure_cap) begin
                        rearb = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (is_idle || is_nseq) begin
                        remaining_d = '0;
                        state_d     = ST_ARB;
                    end else if (is_seq) begin
                        remaining_d = remaining_q - 4'd1;
                        rearb       = (remaining_q == 4'd1);
                    end
                end
                ST_LOCK: begin
                    if (!I_AHBARB_HLOCK[cur_idx]) state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
            if (rearb) begin
                if (I_AHBARB_HLOCK[cur_idx] && I_AHBARB_HBUSREQ[cur_idx]) begin
                    state_d = ST_LOCK;
                end else begin
                    state_d         = ST_ARB;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    if (winner != cur_idx) last_d = winner;
                end
            end
            if (grant_d != grant_q) tenure_d = '0;
        end
    end

    always_ff @(posedge I_AHBARB_HCLK or posedge I_AHBARB_HRESET) begin
        if (I_AHBARB_HRESET) begin
            state_q     <= ST_ARB;
            grant_q     <= '0;
            grant_q[DEF_IDX] <= 1'b1;
            master_q    <= '0;
            mastlock_q  <= 1'b0;
            last_q      <= DEF_IDX;
            remaining_q <= '0;
            tenure_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            master_q    <= master_d;
            mastlock_q  <= mastlock_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            tenure_q    <= tenure_d;
        end
    end

    assign O_AHBARB_HGRANT    = grant_q;
    assign O_AHBARB_HMASTER   = master_q;
    assign O_AHBARB_HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahbarb.sv
// Bench for ahbarb: directed bus scenarios plus randomized traffic, all
// compared every cycle against a behavioural arbitration model.
module tb_ahbarb;

    localparam int MAXT = 16;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011,
                           INCR8 = 3'b101, INCR16 = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hbusreq, hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner index, beats still owed by a fixed burst, lock hold flag.
    int m_owner, m_last, m_beats, m_tenure, m_addr_owner;
    bit m_locked, m_addr_lock;

    ahbarb #(
        .NUM_MASTERS(4),
        .DEFAULT_MASTER(0),
        .MAX_TENURE(MAXT)
    ) dut (
        .I_AHBARB_HCLK(clk),
        .I_AHBARB_HRESET(rst),
        .I_AHBARB_HBUSREQ(hbusreq),
        .I_AHBARB_HLOCK(hlock),
        .I_AHBARB_HTRANS(htrans),
        .I_AHBARB_HBURST(hburst),
        .I_AHBARB_HREADY(hready),
        .O_AHBARB_HGRANT(hgrant),
        .O_AHBARB_HMASTER(hmaster),
        .O_AHBARB_HMASTLOCK(hmastlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 0; m_beats = 0; m_tenure = 0;
        m_addr_owner = 0; m_locked = 0; m_addr_lock = 0;
    endtask

    task automatic model_step();
        int cur, winner, b;
        bit rearb, excl, others;
        logic [3:0] self_mask;
        if (!hready) return;
        cur       = m_owner;
        rearb     = 0;
        excl      = 0;
        self_mask = 4'b0001 << cur;
        others    = |(hbusreq & ~self_mask);
        m_addr_owner = cur;
        m_addr_lock  = hlock[cur];
        if (m_locked) begin
            if (!hlock[cur]) m_locked = 0;
        end else if (m_beats > 0) begin
            if (htrans == IDLE || htrans == NSEQ) m_beats = 0;
            else if (htrans == SEQ) begin
                m_beats--;
                rearb = (m_beats == 0);
            end
        end else begin
            if (htrans[1] && m_tenure < 255) m_tenure++;
            b = int'(hburst);
            if (htrans == NSEQ && b >= 2) m_beats = (4 << ((b - 2) / 2)) - 1;
            else begin
                excl  = (m_tenure >= MAXT) && others;
                rearb = !(hburst == INCR && htrans != IDLE) || excl;
            end
        end
        if (rearb) begin
            if (hlock[cur] && hbusreq[cur]) m_locked = 1;
            else begin
                winner = 0;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last + k) % 4;
                    if (hbusreq[c] && !(excl && c == cur)) begin
                        winner = c;
                        break;
                    end
                end
                if (winner != cur) begin
                    m_owner = winner; m_last = winner; m_tenure = 0;
                end
            end
        end
    endtask

    task automatic compare(input string where);
        logic [3:0] eg;
        eg = 4'b0001 << m_owner;
        check({where, ".grant"}, hgrant, eg);
        check({where, ".master"}, hmaster, m_addr_owner);
        check({where, ".mastlock"}, hmastlock, m_addr_lock);
        check({where, ".onehot"}, $onehot(hgrant), 1);
    endtask

    task automatic cyc(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input string where);
        hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare(where);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        compare("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r_req, r_lk;
        logic [1:0] r_tr;
        logic [2:0] r_bu;
        int sel;

        // Idle: default master holds the grant indefinitely.
        do_reset();
        repeat (6) cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, "idle");
        check("idle_grant", hgrant, 4'b0001);

        // SINGLE traffic from masters 1 and 2 alternates every edge.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0110, 4'b0000, NSEQ, SINGLE, 1'b1, "rr");
            check("rr_alt", hgrant, (i % 2 == 0) ? 4'b0010 : 4'b0100);
        end

        // INCR8 from master 1 with stalls and a BUSY; master 3 waits.
        do_reset();
        cyc(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, "b8_req");
        cyc(4'b1010, 4'b0000, NSEQ, INCR8, 1'b1, "b8");
        check("b8_hold", hgrant, 4'b0010);
        cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b1, "b8");
        cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b0, "b8");
        cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b0, "b8");
        check("b8_hold", hgrant, 4'b0010);
        cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b1, "b8");
        cyc(4'b1010, 4'b0000, BUSY, INCR8, 1'b1, "b8");
        for (int beat = 4; beat <= 7; beat++) begin
            cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b1, "b8");
            check("b8_hold", hgrant, 4'b0010);
        end
        cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b1, "b8");
        check("b8_switch", hgrant, 4'b1000);

        // Undefined INCR from master 2 is capped at MAXT beats.
        do_reset();
        cyc(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, "ten_req");
        for (int beat = 1; beat <= MAXT; beat++) begin
            cyc(4'b0101, 4'b0000, (beat == 1) ? NSEQ : SEQ, INCR, 1'b1, "ten");
            if (beat < MAXT) check("ten_hold", hgrant, 4'b0100);
            else             check("ten_move", hgrant, 4'b0001);
        end

        // Locked INCR4 + SINGLEs from master 3 hold the bus until HLOCK drops.
        do_reset();
        cyc(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, "lk_req");
        cyc(4'b1111, 4'b1000, NSEQ, INCR4, 1'b1, "lk");
        for (int beat = 0; beat < 3; beat++) cyc(4'b1111, 4'b1000, SEQ, INCR4, 1'b1, "lk");
        for (int n = 0; n < 4; n++) begin
            cyc(4'b1111, 4'b1000, NSEQ, SINGLE, 1'b1, "lk");
            check("lk_grant", hgrant, 4'b1000);
            check("lk_master", hmaster, 2'd3);
            check("lk_mastlock", hmastlock, 1'b1);
        end
        cyc(4'b1111, 4'b0000, NSEQ, SINGLE, 1'b1, "lk_drop");
        check("lk_drop_grant", hgrant, 4'b1000);
        cyc(4'b1111, 4'b0000, NSEQ, SINGLE, 1'b1, "lk_rel");
        check("lk_release", hgrant, 4'b0001);

        // Reset mid INCR16 abandons the burst.
        do_reset();
        cyc(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, "r16_req");
        cyc(4'b0010, 4'b0000, NSEQ, INCR16, 1'b1, "r16");
        cyc(4'b0010, 4'b0000, SEQ, INCR16, 1'b1, "r16");
        htrans = SEQ;
        rst = 1'b1;
        #1;
        check("r16_rst_grant", hgrant, 4'b0001);
        check("r16_rst_master", hmaster, 2'd0);
        check("r16_rst_mastlock", hmastlock, 1'b0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        cyc(4'b0100, 4'b0000, SEQ, INCR16, 1'b1, "r16_post");
        check("r16_post_arb", hgrant, 4'b0100);

        // Randomized traffic with sticky requests, locks and burst types.
        do_reset();
        r_req = 4'b0110; r_lk = '0; r_bu = SINGLE;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r_req = 4'($urandom);
            if ($urandom_range(0, 9) == 0)
                r_lk = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            sel = $urandom_range(0, 7);
            r_tr = (sel == 0) ? IDLE : (sel == 1) ? BUSY : (sel < 4) ? NSEQ : SEQ;
            if (r_tr == NSEQ) r_bu = 3'($urandom);
            cyc(r_req, r_lk, r_tr, r_bu, $urandom_range(0, 3) != 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
